// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store unit: RISC-V func3 codes, FSM states and
// the func3 legality rule used at request acceptance.
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_FIRST  = 2'd1,
    LSU_SECOND = 2'd2,
    LSU_RESP   = 2'd3
  } lsu_state_e;

  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    if (write)
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline request/response and word-aligned data-memory port of the LSU.
// master = the LSU itself, slave = the pipeline plus memory environment.
interface lsu_ctrl_if #(parameter int ADDR_W = 32);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_write, req_func3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_func3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for one access: byte enables and lane-aligned store data
// for either half of a (possibly split) word transaction.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  off,
  input  logic        write,
  input  logic        half,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        misal
);

  logic [3:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [63:0] wide;

  always_comb begin
    size_mask = 4'b1111;
    case (func3)
      F3_LB, F3_LBU: size_mask = 4'b0001;
      F3_LH, F3_LHU: size_mask = 4'b0011;
      default:       size_mask = 4'b1111;
    endcase
  end

  // Shifting across a two-word window: the upper nibble/word is what spills
  // into the next aligned word.
  assign lane_mask  = {4'b0000, size_mask} << off;
  assign wide       = {32'h0, wdata} << {off, 3'b000};
  assign misal      = |lane_mask[7:4];
  assign be         = half ? lane_mask[7:4] : lane_mask[3:0];
  assign wdata_lane = !write ? 32'h0 : (half ? wide[63:32] : wide[31:0]);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: captures one byte-addressed access, issues one or two
// word transactions on the memory port, and returns the extended load data.
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic        clk,
  input logic        rst_n,
  lsu_ctrl_if.master bus
);
  import lsu_ctrl_pkg::*;

  lsu_state_e  state;
  logic [2:0]  func3_p0;
  logic [1:0]  off_p0;
  logic        write_p0;
  logic        misal_p0;
  logic [31:0] wdata_p0;
  logic [31:0] lo_p1;

  logic        idle;
  logic [2:0]  al_func3;
  logic [1:0]  al_off;
  logic        al_write;
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic [31:0] al_lane;
  logic        al_misal;
  logic [55:0] rd_win;
  logic [31:0] rd_asm;

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] r_s;
    b_s = raw[7:0];
    h_s = raw[15:0];
    case (f3)
      F3_LB:   r_s = b_s;
      F3_LH:   r_s = h_s;
      F3_LBU:  r_s = {24'h0, raw[7:0]};
      F3_LHU:  r_s = {16'h0, raw[15:0]};
      default: r_s = raw;
    endcase
    return r_s;
  endfunction

  assign idle          = (state == LSU_IDLE);
  assign bus.req_ready = idle;

  // In IDLE the aligner looks at the live request so the first transaction can
  // be registered at the accept edge; afterwards it sees the captured copy.
  assign al_func3 = idle ? bus.req_func3      : func3_p0;
  assign al_off   = idle ? bus.req_addr[1:0]  : off_p0;
  assign al_write = idle ? bus.req_write      : write_p0;
  assign al_wdata = idle ? bus.req_wdata      : wdata_p0;

  lsu_align u_align (
    .func3      (al_func3),
    .off        (al_off),
    .write      (al_write),
    .half       (state == LSU_FIRST),
    .wdata      (al_wdata),
    .be         (al_be),
    .wdata_lane (al_lane),
    .misal      (al_misal)
  );

  // Byte window in access order; the result starts at the access offset.
  assign rd_win = (state == LSU_SECOND) ? {bus.mem_rdata[23:0], lo_p1}
                                        : {24'h0, bus.mem_rdata};

  always_comb begin
    rd_asm = rd_win[31:0];
    case (off_p0)
      2'd1:    rd_asm = rd_win[39:8];
      2'd2:    rd_asm = rd_win[47:16];
      2'd3:    rd_asm = rd_win[55:24];
      default: rd_asm = rd_win[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= LSU_IDLE;
      func3_p0       <= '0;
      off_p0         <= '0;
      write_p0       <= 1'b0;
      misal_p0       <= 1'b0;
      wdata_p0       <= '0;
      lo_p1          <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_be     <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      case (state)
        // p0: request capture
        LSU_IDLE: begin
          if (bus.req_valid) begin
            func3_p0 <= bus.req_func3;
            off_p0   <= bus.req_addr[1:0];
            write_p0 <= bus.req_write;
            wdata_p0 <= bus.req_wdata;
            misal_p0 <= al_misal;
            if (f3_legal(bus.req_write, bus.req_func3)) begin
              state         <= LSU_FIRST;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_write;
              bus.mem_be    <= al_be;
              bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              bus.mem_wdata <= al_lane;
            end else begin
              state          <= LSU_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end
          end
        end
        // p1: first word transaction
        LSU_FIRST: begin
          if (bus.mem_ack) begin
            lo_p1 <= bus.mem_rdata;
            if (misal_p0) begin
              state         <= LSU_SECOND;
              bus.mem_be    <= al_be;
              bus.mem_addr  <= bus.mem_addr + ADDR_W'(4);
              bus.mem_wdata <= al_lane;
            end else begin
              state          <= LSU_RESP;
              bus.mem_req    <= 1'b0;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b0;
              bus.resp_rdata <= write_p0 ? 32'h0 : extend_load(func3_p0, rd_asm);
            end
          end
        end
        // p2: second word transaction of a split access
        LSU_SECOND: begin
          if (bus.mem_ack) begin
            state          <= LSU_RESP;
            bus.mem_req    <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= write_p0 ? 32'h0 : extend_load(func3_p0, rd_asm);
          end
        end
        LSU_RESP: begin
          state          <= LSU_IDLE;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed and random accesses against a byte-addressed
// reference memory, with a wait-state memory responder.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_W(32)) bus ();
  lsu_ctrl #(.ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  txn_t       txn_log[$];
  logic [7:0] dut_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  int vectors  = 0;
  int fails    = 0;
  int wait_cfg = 0;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction
  function automatic logic [7:0] dut_rd(input logic [31:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction
  function automatic logic [31:0] bemask(input logic [3:0] be);
    logic [31:0] m;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{be[l]}};
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] val);
    for (int l = 0; l < 4; l++) begin
      dut_mem[a + 32'(l)] = val[8*l +: 8];
      ref_mem[a + 32'(l)] = val[8*l +: 8];
    end
  endtask

  // Memory responder: acks after wait_cfg cycles, holds-checks the request.
  initial begin : responder
    txn_t        cur;
    int          left;
    logic        active;
    logic [31:0] rd;
    active = 1'b0;
    left = 0;
    cur = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (!rst_n || !bus.mem_req) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          cur = '{addr: bus.mem_addr, be: bus.mem_be, we: bus.mem_we, wdata: bus.mem_wdata};
          txn_log.push_back(cur);
          active = 1'b1;
          left = wait_cfg;
        end else begin
          check("hold.addr", bus.mem_addr, cur.addr);
          check("hold.be", 32'(bus.mem_be), 32'(cur.be));
          check("hold.we", 32'(bus.mem_we), 32'(cur.we));
          check("hold.wdata", bus.mem_wdata, cur.wdata);
        end
        if (left == 0) begin
          for (int l = 0; l < 4; l++) rd[8*l +: 8] = dut_rd(cur.addr + 32'(l));
          if (cur.we)
            for (int l = 0; l < 4; l++)
              if (cur.be[l]) dut_mem[cur.addr + 32'(l)] = cur.wdata[8*l +: 8];
          bus.mem_ack = 1'b1;
          bus.mem_rdata = rd;
          active = 1'b0;
        end else begin
          left--;
        end
      end
    end
  end

  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int waits);
    bit          legal;
    int          size, n, lat, edges;
    logic [31:0] ea[2];
    logic [31:0] ew[2];
    logic [3:0]  eb[2];
    logic [31:0] a, v, exp_rd;
    txn_t        t;

    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    n = 0;
    v = '0;
    for (int k = 0; k < 2; k++) begin ea[k] = '0; eb[k] = '0; ew[k] = '0; end
    // Group the touched bytes by the aligned word they live in.
    for (int k = 0; k < size; k++) begin
      a = addr + 32'(k);
      if (n == 0 || ea[n-1] != {a[31:2], 2'b00}) begin
        ea[n] = {a[31:2], 2'b00};
        n++;
      end
      eb[n-1][a[1:0]] = 1'b1;
      ew[n-1][{a[1:0], 3'b000} +: 8] = wd[8*k +: 8];
      v[8*k +: 8] = ref_rd(a);
    end
    if (!legal || wr) exp_rd = '0;
    else if (f3 == 3'd0) exp_rd = {{24{v[7]}}, v[7:0]};
    else if (f3 == 3'd1) exp_rd = {{16{v[15]}}, v[15:0]};
    else exp_rd = v;
    if (legal && wr)
      for (int k = 0; k < size; k++) ref_mem[addr + 32'(k)] = wd[8*k +: 8];
    if (!legal) n = 0;
    lat = legal ? 1 + n * (1 + waits) : 1;

    wait_cfg = waits;
    txn_log.delete();
    edges = 0;
    while (bus.req_ready !== 1'b1 && edges < 20) begin @(posedge clk); #1; edges++; end
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_func3 = f3;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_func3 = 3'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    edges = 1;
    while (bus.resp_valid !== 1'b1 && edges < 60) begin @(posedge clk); #1; edges++; end
    check({tag, ".latency"}, 32'(edges), 32'(lat));
    check({tag, ".err"}, 32'(bus.resp_err), 32'(!legal));
    check({tag, ".rdata"}, bus.resp_rdata, exp_rd);
    @(posedge clk); #1;
    check({tag, ".pulse"}, 32'(bus.resp_valid), 32'(0));
    check({tag, ".ready"}, 32'(bus.req_ready), 32'(1));
    check({tag, ".ntxn"}, 32'(txn_log.size()), 32'(n));
    for (int i = 0; i < n && i < txn_log.size(); i++) begin
      t = txn_log[i];
      check({tag, ".addr"}, t.addr, ea[i]);
      check({tag, ".be"}, 32'(t.be), 32'(eb[i]));
      check({tag, ".we"}, 32'(t.we), 32'(wr));
      if (wr) check({tag, ".wdata"}, t.wdata & bemask(eb[i]), ew[i]);
    end
    if (legal && wr)
      for (int k = 0; k < 4; k++)
        check({tag, ".mem"}, 32'(dut_rd(addr + 32'(k))), 32'(ref_rd(addr + 32'(k))));
  endtask

  initial begin : stimulus
    int          cnt;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] bases[3];

    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_func3 = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 32'(bus.req_ready), 32'(1));
    check("rst.resp_valid", 32'(bus.resp_valid), 32'(0));
    check("rst.resp_rdata", bus.resp_rdata, 32'h0);
    check("rst.resp_err", 32'(bus.resp_err), 32'(0));
    check("rst.mem_req", 32'(bus.mem_req), 32'(0));
    check("rst.mem_we", 32'(bus.mem_we), 32'(0));
    check("rst.mem_be", 32'(bus.mem_be), 32'(0));
    check("rst.mem_addr", bus.mem_addr, 32'h0);
    check("rst.mem_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    set_word(32'h100, 32'h80FF0102);
    do_req("lw_aligned", 1'b0, F3_LW, 32'h100, 32'h0, 0);
    do_req("sw_split", 1'b1, F3_SW, 32'h102, 32'hAABBCCDD, 0);
    set_word(32'h100, 32'h7F000000);
    set_word(32'h104, 32'h00000080);
    do_req("lh_split", 1'b0, F3_LH, 32'h103, 32'h0, 0);
    do_req("lhu_split", 1'b0, F3_LHU, 32'h103, 32'h0, 1);
    set_word(32'h200, 32'h00009C00);
    do_req("lb", 1'b0, F3_LB, 32'h201, 32'h0, 0);
    do_req("lbu", 1'b0, F3_LBU, 32'h201, 32'h0, 2);
    do_req("ill_load", 1'b0, 3'b011, 32'h100, 32'h0, 0);
    do_req("ill_store", 1'b1, 3'b100, 32'h104, 32'h12345678, 0);
    do_req("sh_wrap", 1'b1, F3_SH, 32'hFFFFFFFF, 32'h00001234, 0);
    do_req("lw_wrap", 1'b0, F3_LW, 32'hFFFFFFFE, 32'h0, 1);
    do_req("lw_wait3", 1'b0, F3_LW, 32'h100, 32'h0, 3);

    // Reset while the second half of a split store is pending.
    wait_cfg = 6;
    txn_log.delete();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_func3 = F3_SW;
    bus.req_addr  = 32'h102;
    bus.req_wdata = 32'h11223344;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cnt = 0;
    while (txn_log.size() < 2 && cnt < 30) begin @(posedge clk); #1; cnt++; end
    check("rst_mid.second", 32'(txn_log.size()), 32'(2));
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid.mem_req", 32'(bus.mem_req), 32'(0));
    check("rst_mid.ready", 32'(bus.req_ready), 32'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rel.ready", 32'(bus.req_ready), 32'(1));
    check("rst_rel.mem_req", 32'(bus.mem_req), 32'(0));
    ref_mem[32'h102] = 8'h44;
    ref_mem[32'h103] = 8'h33;
    for (int k = 0; k < 8; k++)
      check("rst_mid.mem", 32'(dut_rd(32'h100 + 32'(k))), 32'(ref_rd(32'h100 + 32'(k))));

    bases[0] = 32'h100;
    bases[1] = 32'h200;
    bases[2] = 32'hFFFFFFF4;
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      if (wr && f3 > 3'd2 && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      if (!wr && (f3 == 3'd3 || f3 > 3'd5) && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(4, 5));
      addr = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 11));
      do_req("rand", wr, f3, addr, $urandom, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
